// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Booth windows {b[2i+1], b[2i], b[2i-1]}
    localparam logic [2:0] DIG_Z0  = 3'b000;
    localparam logic [2:0] DIG_P1A = 3'b001;
    localparam logic [2:0] DIG_P1B = 3'b010;
    localparam logic [2:0] DIG_P2  = 3'b011;
    localparam logic [2:0] DIG_M2  = 3'b100;
    localparam logic [2:0] DIG_M1A = 3'b101;
    localparam logic [2:0] DIG_M1B = 3'b110;
    localparam logic [2:0] DIG_Z1  = 3'b111;

    function automatic int unsigned digit_count(input int unsigned width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_digit_pp.sv
// Radix-4 Booth partial-product selector; negative digits return the ones
// complement and raise neg so the +1 can ride on the accumulator add.
module booth_digit_pp
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [2:0]       digit,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+2:0] pp,
    output logic             neg
);

    logic [WIDTH+2:0] m1;
    logic [WIDTH+2:0] m2;

    assign m1 = {m[WIDTH+1], m};
    assign m2 = {m, 1'b0};

    always_comb begin
        pp  = '0;
        neg = 1'b0;
        case (digit)
            DIG_P1A, DIG_P1B: pp = m1;
            DIG_P2:           pp = m2;
            DIG_M2: begin
                pp  = ~m2;
                neg = 1'b1;
            end
            DIG_M1A, DIG_M1B: begin
                pp  = ~m1;
                neg = 1'b1;
            end
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier: one digit per clock, start/done handshake,
// signed or unsigned operands selected per operation.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned N  = digit_count(WIDTH);
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned XW = WIDTH + 2;
    localparam int unsigned AW = 2 * XW + 1;

    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q;
    logic [XW-1:0]      m_q;
    logic [AW-1:0]      acc_q;
    logic               bm1_q;
    logic               accept;
    logic               last;
    logic [XW-1:0]      a_ext;
    logic [XW-1:0]      b_ext;
    logic [XW:0]        pp;
    logic               neg;
    logic [XW:0]        sum;
    logic signed [AW-1:0] acc_cat;
    logic signed [AW-1:0] acc_sh;

    assign accept = start && (state_q != RUN);
    assign last   = (cnt_q == CW'(N - 1));
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);

    assign a_ext = {{2{is_signed & a[WIDTH-1]}}, a};
    assign b_ext = {{2{is_signed & b[WIDTH-1]}}, b};

    booth_digit_pp #(.WIDTH(WIDTH)) u_pp (
        .digit ({acc_q[1:0], bm1_q}),
        .m     (m_q),
        .pp    (pp),
        .neg   (neg)
    );

    // Upper W+3 bits take the partial product; the whole word then shifts
    // right arithmetically so the multiplier bits drain out of the bottom.
    assign sum     = acc_q[AW-1:XW] + pp + {{XW{1'b0}}, neg};
    assign acc_cat = {sum, acc_q[XW-1:0]};
    assign acc_sh  = acc_cat >>> 2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            bm1_q   <= 1'b0;
            product <= '0;
        end else if (accept) begin
            cnt_q <= '0;
            m_q   <= a_ext;
            acc_q <= {{(XW + 1){1'b0}}, b_ext};
            bm1_q <= 1'b0;
        end else if (state_q == RUN) begin
            acc_q <= acc_sh;
            bm1_q <= acc_q[1];
            cnt_q <= last ? '0 : cnt_q + 1'b1;
            if (last) begin
                product <= acc_sh[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: 16-bit and 8-bit instances checked
// against a plain-arithmetic multiply and a cycle-level timing model.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        s16, sg16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    logic        s8, sg8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    booth_mul_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .is_signed(sg16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .product(p16)
    );

    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .is_signed(sg8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          d;
        int          due;
        logic [31:0] prod;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] held[2];
    int          free_at[2];
    int          errors = 0;
    int          checks = 0;

    function automatic int wdt(input int d);
        return (d == 0) ? 16 : 8;
    endfunction

    function automatic int ndig(input int d);
        return wdt(d) / 2 + 1;
    endfunction

    function automatic logic [31:0] ref_mul(input int w, input logic sg,
                                            input logic [15:0] x, input logic [15:0] y);
        longint xa, ya, p;
        xa = longint'(x);
        ya = longint'(y);
        if (sg && x[w-1]) xa = xa - (longint'(1) << w);
        if (sg && y[w-1]) ya = ya - (longint'(1) << w);
        p = xa * ya;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    function automatic logic [15:0] corner(input int w, input int k);
        logic [15:0] v;
        case (k)
            0:       v = 16'h0000;
            1:       v = 16'hFFFF >> (16 - w);
            2:       v = 16'h0001 << (w - 1);
            default: v = (16'h0001 << (w - 1)) - 16'h0001;
        endcase
        return v;
    endfunction

    function automatic int find(input int d);
        foreach (sb[i]) if (sb[i].d == d) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s w%0d @cyc %0d: got %h expected %h", nm, wdt(d), cyc, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic bz, input logic dn, input logic [31:0] pr);
        int   i;
        logic eb;
        i  = find(d);
        eb = (i >= 0) && (cyc >= sb[i].due - ndig(d)) && (cyc < sb[i].due);
        chk("busy", d, 32'(bz), 32'(eb));
        if (i >= 0 && sb[i].due == cyc) begin
            chk("done", d, 32'(dn), 32'd1);
            chk("product", d, pr, sb[i].prod);
            held[d] = sb[i].prod;
            sb.delete(i);
        end else begin
            chk("no_done", d, 32'(dn), 32'd0);
            chk("product_hold", d, pr, held[d]);
        end
    endtask

    always @(negedge clk) begin
        mon(0, busy16, done16, p16);
        mon(1, busy8, done8, {16'h0000, p8});
    end

    // Start is raised and held until the model says the DUT can accept.
    task automatic issue(input int d, input logic sg, input logic [15:0] x,
                         input logic [15:0] y, input logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        if (d == 0) begin
            s16 = 1'b1; sg16 = sg; a16 = x; b16 = y;
        end else begin
            s8 = 1'b1; sg8 = sg; a8 = x[7:0]; b8 = y[7:0];
        end
        for (int k = 0; k < 64 && !ok; k++) begin
            @(posedge clk);
            #1;
            if (cyc >= free_at[d]) ok = 1'b1;
        end
        if (!ok) begin
            $display("FAIL accept_timeout w%0d", wdt(d));
            errors++;
        end
        sb.push_back('{d: d, due: cyc + ndig(d), prod: exp});
        free_at[d] = cyc + ndig(d) + 1;
        if (d == 0) begin
            s16 = 1'b0; sg16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
        end else begin
            s8 = 1'b0; sg8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        end
    endtask

    task automatic rand_op(input int d);
        logic        sg;
        logic [15:0] x, y;
        int          w;
        w  = wdt(d);
        sg = 1'($urandom_range(0, 1));
        x  = ($urandom_range(0, 3) == 0) ? corner(w, $urandom_range(0, 3)) : 16'($urandom);
        y  = ($urandom_range(0, 3) == 0) ? corner(w, $urandom_range(0, 3)) : 16'($urandom);
        if (d == 1) begin
            x = x & 16'h00FF;
            y = y & 16'h00FF;
        end
        issue(d, sg, x, y, ref_mul(w, sg, x, y));
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    endtask

    initial begin
        s16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
        s8 = 1'b0;  sg8 = 1'b0;  a8 = '0;  b8 = '0;
        held[0] = '0; held[1] = '0;
        free_at[0] = 0; free_at[1] = 0;

        repeat (3) @(negedge clk);
        chk("reset_product", 0, p16, 32'd0);
        chk("reset_busy", 0, 32'(busy16), 32'd0);
        #1 rst_n = 1'b1;

        issue(0, 1'b1, 16'd3, 16'd5, 32'd15);
        issue(0, 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001);
        issue(0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        issue(0, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000);
        issue(0, 1'b0, 16'h8000, 16'h0002, 32'h0001_0000);
        issue(0, 1'b1, 16'd3, 16'd5, 32'd15);
        issue(0, 1'b1, 16'd7, 16'd7, 32'd49);
        issue(1, 1'b1, 16'd127, 16'h0080, 32'h0000_C080);
        issue(1, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01);
        drain();

        for (int r = 0; r < 20; r++) begin
            rand_op(0);
            rand_op(1);
        end
        drain();

        // Mid-run reset: in-flight result is dropped and outputs clear at once.
        issue(0, 1'b1, 16'd100, 16'd100, 32'd10000);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        held[0] = '0; held[1] = '0;
        free_at[0] = 0; free_at[1] = 0;
        #1;
        chk("rst_busy", 0, 32'(busy16), 32'd0);
        chk("rst_done", 0, 32'(done16), 32'd0);
        chk("rst_product", 0, p16, 32'd0);
        chk("rst_product", 1, {16'h0000, p8}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        issue(0, 1'b1, 16'd2, 16'd2, 32'd4);
        issue(1, 1'b0, 16'd2, 16'd2, 32'd4);
        drain();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Iterative radix-4 Booth multiplier, parametrised in operand width, with selectable signed or unsigned operation. It retires one Booth digit per clock and uses a start/done handshake. It is the sequential successor to the team's 16-bit combinational Booth partial-product selector, and is used wherever a full multiply is needed without a parallel array.

## Interface
- WIDTH, 16, operand width in bits; even, at least 4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when the block can accept
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
- a  input  WIDTH  multiplicand; captured with start
- b  input  WIDTH  multiplier; captured with start
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse when product is valid
- product  output  2*WIDTH  result; held until the next accepted start

## Operation
- States:
  - IDLE: reset state; accepts start.
  - RUN: iterating.
  - DONE: done=1; also accepts start.
- Capture on acceptance:
  - a and b are extended to WIDTH+2 bits: sign-extended if is_signed, zero-extended otherwise.
  - The extended b gets an implicit 0 appended below bit 0.
  - Digit count N = WIDTH/2+1; for WIDTH=16, N=9.
- Digit decode uses a 3-bit window {b[2i+1], b[2i], b[2i-1]}:
  - 000 → 0
  - 001, 010 → +M
  - 011 → +2M
  - 100 → −2M
  - 101, 110 → −M
  - 111 → 0
- Partial products are WIDTH+3 bits, sign-correct. Negation is ones-complement plus 1, folded into the add.
- Accumulator:
  - Width is 2*(WIDTH+2)+1 bits.
  - Each RUN cycle adds the partial product to the upper part, then shifts the whole accumulator right arithmetically by 2.
  - After N digits, product = accumulator bits [2*WIDTH-1:0]. This is exact in both modes.
- Digit counter counts 0..N-1. RUN → DONE when the counter reaches N-1.
- DONE → RUN if start=1, otherwise DONE → IDLE.
- start in RUN is ignored: no queuing, operands are not re-captured.
- Changes to a, b or is_signed after capture have no effect.

## Timing
- Reset values: busy=0, done=0, product=0; state IDLE; counter 0.
- Assertion of rst_n low takes effect immediately, including mid-RUN. The in-flight result is discarded and no done is issued.
- Cycle numbering for a start accepted at rising edge t:
  - busy=1 during cycles t+1 … t+N.
  - done=1 and product valid in cycle t+N+1, i.e. N+1 cycles latency.
  - busy=0 during DONE.
- Back-to-back: start high in the DONE cycle is accepted. busy rises the next cycle, so throughput is one result per N+1 cycles.
- done is never high for two consecutive cycles.
- product changes only on the edge entering DONE. It is stable in IDLE, RUN and DONE of the next operation until that operation completes.
- done and busy are never both 1.

## Structure
- Package booth_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the 3-bit digit encodings;
  - a function returning N from WIDTH.
- Sub-module booth_digit_pp is the natural split. It is the combinational, WIDTH-parametrised partial-product selector.
  - Inputs: 3-bit digit and the (WIDTH+2)-bit extended multiplicand.
  - Output: the (WIDTH+3)-bit signed partial product.
  - Replaces the tri-state style of the earlier selector with a plain mux; no z values.
- The top level holds the FSM, the digit counter, the accumulator and the output register.

## Test plan
- WIDTH=16, signed, a=3, b=5, start for 1 cycle → done exactly 10 cycles after the start edge; product=15; busy high for 9 cycles.
- WIDTH=16, signed, a=0xFFFF (−1), b=0xFFFF → product=0x00000001. Same operands unsigned → product=0xFFFE0001.
- WIDTH=16, signed, a=b=0x8000 → product=0x40000000. Unsigned 0x8000×0x0002 → 0x00010000.
- Start 3×5, then hold start high with a=7, b=7 during RUN → first result 15; second start is accepted only in the DONE cycle; next result 49 arrives 10 cycles later.
- Start 100×100, assert rst_n low at cycle 4 of RUN → busy, done and product all 0 immediately; no done pulse afterwards. After release, 2×2 gives 4.
- WIDTH=8 instance, signed, a=127, b=0x80 (−128) → product=0xC080 (−16256), done 6 cycles after start. Random signed and unsigned operands are checked against a reference multiply.
